muldiv_sched: RTL and testbench

// - Execute-stage multiply/divide sequencer beside the ALU: owns the HI/LO registers, accepts one mult/div op, counts
//   out a fixed multi-cycle latency, then commits HI/LO and produces the pipeline stall for MDU-using decode instructions.
// - The ALU keeps single-cycle ops; this block handles mult/multu/div/divu/mthi/mtlo/mfhi/mflo.

---
 rtl/muldiv_sched_pkg.sv | 29 ++
 rtl/muldiv_sched_core.sv | 57 +++++
 rtl/muldiv_sched.sv | 114 +++++++++++
 tb/tb_muldiv_sched.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/muldiv_sched_pkg.sv
// Shared MDU definitions: 3-bit MdOp encodings, default latencies and sequencer state type.
package mips_defs;

    localparam logic [2:0] MDOP_NONE  = 3'd0;
    localparam logic [2:0] MDOP_MULT  = 3'd1;
    localparam logic [2:0] MDOP_MULTU = 3'd2;
    localparam logic [2:0] MDOP_DIV   = 3'd3;
    localparam logic [2:0] MDOP_DIVU  = 3'd4;
    localparam logic [2:0] MDOP_MTHI  = 3'd5;
    localparam logic [2:0] MDOP_MTLO  = 3'd6;
    localparam logic [2:0] MDOP_RSVD  = 3'd7;

    localparam int DEF_MUL_CYC = 5;
    localparam int DEF_DIV_CYC = 10;

    typedef enum logic {
        MD_IDLE = 1'b0,
        MD_RUN  = 1'b1
    } md_state_e;

    function automatic logic is_arith(input logic [2:0] op);
        return (op >= MDOP_MULT) && (op <= MDOP_DIVU);
    endfunction

    function automatic logic is_mul(input logic [2:0] op);
        return (op == MDOP_MULT) || (op == MDOP_MULTU);
    endfunction

endpackage

// File: rtl/muldiv_sched_core.sv
// Combinational multiply/divide datapath: op, a, b -> {hi, lo} plus a result-valid flag.
module muldiv_core
    import mips_defs::*;
(
    input  logic [2:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        valid
);

    logic        sgn;
    logic [63:0] ext_a;
    logic [63:0] ext_b;
    logic [63:0] prod;
    logic [31:0] mag_a;
    logic [31:0] mag_b;
    logic [31:0] div_b;
    logic [31:0] q_u;
    logic [31:0] r_u;
    logic [31:0] quo;
    logic [31:0] rem;

    // Sign-extended operands make one 64-bit multiplier serve both mult and multu.
    always_comb begin
        sgn   = (op == MDOP_MULT) || (op == MDOP_DIV);
        ext_a = sgn ? {{32{a[31]}}, a} : {32'd0, a};
        ext_b = sgn ? {{32{b[31]}}, b} : {32'd0, b};
        prod  = ext_a * ext_b;

        // Magnitude divide then fix signs: truncating quotient, remainder follows dividend.
        mag_a = (sgn && a[31]) ? -a : a;
        mag_b = (sgn && b[31]) ? -b : b;
        div_b = (b == 32'd0) ? 32'd1 : mag_b;
        q_u   = mag_a / div_b;
        r_u   = mag_a % div_b;
        quo   = (sgn && (a[31] ^ b[31])) ? -q_u : q_u;
        rem   = (sgn && a[31]) ? -r_u : r_u;
    end

    always_comb begin
        hi    = 32'd0;
        lo    = 32'd0;
        valid = 1'b0;
        if (is_mul(op)) begin
            hi    = prod[63:32];
            lo    = prod[31:0];
            valid = 1'b1;
        end else if (op == MDOP_DIV || op == MDOP_DIVU) begin
            hi    = rem;
            lo    = quo;
            valid = (b != 32'd0);
        end
    end

endmodule

// File: rtl/muldiv_sched.sv
// MDU sequencer: accepts one mult/div, holds the result pending for a fixed latency, then commits HI/LO.
module muldiv_sched
    import mips_defs::*;
#(
    parameter int MUL_CYC = DEF_MUL_CYC,
    parameter int DIV_CYC = DEF_DIV_CYC,
    parameter int CNT_W   = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [2:0]  MdOp,
    input  logic [31:0] Operand1,
    input  logic [31:0] Operand2,
    input  logic        Flush,
    input  logic        MdUseD,
    input  logic        RdSel,
    output logic        Busy,
    output logic        Stall,
    output logic [31:0] RdData,
    output logic [31:0] HI,
    output logic [31:0] LO
);

    md_state_e        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [31:0]      ph_q, ph_d;
    logic [31:0]      pl_q, pl_d;
    logic             pv_q, pv_d;
    logic [31:0]      hi_q, hi_d;
    logic [31:0]      lo_q, lo_d;
    logic             start;
    logic [31:0]      core_hi;
    logic [31:0]      core_lo;
    logic             core_valid;

    muldiv_core u_core (
        .op    (MdOp),
        .a     (Operand1),
        .b     (Operand2),
        .hi    (core_hi),
        .lo    (core_lo),
        .valid (core_valid)
    );

    assign start = (state_q == MD_IDLE) && !Flush && is_arith(MdOp);

    // NOTE: every _d defaults to its _q first so no path through the case leaves a latch.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ph_d    = ph_q;
        pl_d    = pl_q;
        pv_d    = pv_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        case (state_q)
            MD_IDLE: begin
                if (start) begin
                    ph_d    = core_hi;
                    pl_d    = core_lo;
                    pv_d    = core_valid;
                    cnt_d   = is_mul(MdOp) ? CNT_W'(MUL_CYC) : CNT_W'(DIV_CYC);
                    state_d = MD_RUN;
                end else if (!Flush && MdOp == MDOP_MTHI) begin
                    hi_d = Operand1;
                end else if (!Flush && MdOp == MDOP_MTLO) begin
                    lo_d = Operand1;
                end
            end
            MD_RUN: begin
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    if (pv_q) begin
                        hi_d = ph_q;
                        lo_d = pl_q;
                    end
                    state_d = MD_IDLE;
                end
            end
            default: state_d = MD_IDLE;
        endcase
    end

    // NOTE: state updates use non-blocking assignment so all flops sample the same pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= MD_IDLE;
            cnt_q   <= '0;
            ph_q    <= '0;
            pl_q    <= '0;
            pv_q    <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ph_q    <= ph_d;
            pl_q    <= pl_d;
            pv_q    <= pv_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    // Stall covers the start cycle too, so a decode-stage mfhi/mflo only ever sees committed values.
    always_comb begin
        Busy   = (state_q == MD_RUN);
        Stall  = MdUseD && (Busy || start);
        RdData = RdSel ? hi_q : lo_q;
        HI     = hi_q;
        LO     = lo_q;
    end

endmodule

// File: tb/tb_muldiv_sched.sv
// Directed bench for muldiv_sched: a vector table of single ops plus hand sequences for stall/flush/reset/back-to-back.
module tb_muldiv_sched;

    logic        clk = 1'b0;
    logic        reset;
    logic [2:0]  MdOp;
    logic [31:0] Operand1;
    logic [31:0] Operand2;
    logic        Flush;
    logic        MdUseD;
    logic        RdSel;
    logic        Busy;
    logic        Stall;
    logic [31:0] RdData;
    logic [31:0] HI;
    logic [31:0] LO;

    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
        int          busy;
    } vec_t;

    vec_t vecs[12];

    muldiv_sched dut (
        .clk      (clk),
        .reset    (reset),
        .MdOp     (MdOp),
        .Operand1 (Operand1),
        .Operand2 (Operand2),
        .Flush    (Flush),
        .MdUseD   (MdUseD),
        .RdSel    (RdSel),
        .Busy     (Busy),
        .Stall    (Stall),
        .RdData   (RdData),
        .HI       (HI),
        .LO       (LO)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Counts Busy cycles until Busy drops, bounded so a stuck DUT still reaches the summary.
    task automatic count_busy(output int cnt);
        cnt = 0;
        while (Busy && cnt < 40) begin
            cnt++;
            step();
        end
        if (cnt >= 40) begin
            n_cmp++;
            n_err++;
            $display("FAIL busy_timeout: Busy still high after %0d cycles", cnt);
        end
    endtask

    initial begin
        int bc;
        int total;

        vecs[0]  = '{3'd1, 32'hFFFF_FFFF, 32'h2,         32'hFFFF_FFFF, 32'hFFFF_FFFE, 5};
        vecs[1]  = '{3'd2, 32'hFFFF_FFFF, 32'h2,         32'h0000_0001, 32'hFFFF_FFFE, 5};
        vecs[2]  = '{3'd3, 32'hFFFF_FFF9, 32'h2,         32'hFFFF_FFFF, 32'hFFFF_FFFD, 10};
        vecs[3]  = '{3'd4, 32'h7,         32'h0,         32'hFFFF_FFFF, 32'hFFFF_FFFD, 10};
        vecs[4]  = '{3'd3, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 10};
        vecs[5]  = '{3'd4, 32'd100,       32'd7,         32'h0000_0002, 32'h0000_000E, 10};
        vecs[6]  = '{3'd3, 32'h7,         32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, 10};
        vecs[7]  = '{3'd5, 32'h1234,      32'h0,         32'h0000_1234, 32'hFFFF_FFFD, 0};
        vecs[8]  = '{3'd6, 32'hABCD,      32'h0,         32'h0000_1234, 32'h0000_ABCD, 0};
        vecs[9]  = '{3'd1, 32'hFFFF_FFFD, 32'h4,         32'hFFFF_FFFF, 32'hFFFF_FFF4, 5};
        vecs[10] = '{3'd2, 32'h0001_0000, 32'h0001_0000, 32'h0000_0001, 32'h0000_0000, 5};
        vecs[11] = '{3'd7, 32'hDEAD_BEEF, 32'h5,         32'h0000_0001, 32'h0000_0000, 0};

        reset = 1'b1; MdOp = 3'd0; Operand1 = '0; Operand2 = '0;
        Flush = 1'b0; MdUseD = 1'b1; RdSel = 1'b0;
        step();
        step();
        check("reset_busy", 32'(Busy), 32'd0);
        check("reset_stall", 32'(Stall), 32'd0);
        check("reset_hi", HI, 32'd0);
        check("reset_lo", LO, 32'd0);
        reset = 1'b0;
        MdUseD = 1'b0;
        step();

        for (int i = 0; i < 12; i++) begin
            MdOp = vecs[i].op; Operand1 = vecs[i].a; Operand2 = vecs[i].b;
            RdSel = i[0];
            step();
            MdOp = 3'd0;
            count_busy(bc);
            check($sformatf("v%0d_busy_cycles", i), 32'(bc), 32'(vecs[i].busy));
            check($sformatf("v%0d_hi", i), HI, vecs[i].hi);
            check($sformatf("v%0d_lo", i), LO, vecs[i].lo);
            check($sformatf("v%0d_rddata", i), RdData, i[0] ? vecs[i].hi : vecs[i].lo);
        end

        // Stall across a mult with mflo waiting in decode; old LO stays visible until commit.
        MdUseD = 1'b1; RdSel = 1'b0;
        MdOp = 3'd1; Operand1 = 32'd5; Operand2 = 32'd6;
        #1;
        check("stall_start_cycle", 32'(Stall), 32'd1);
        step();
        MdOp = 3'd0;
        for (int k = 0; k < 5; k++) begin
            check($sformatf("stall_busy_%0d", k), 32'(Stall), 32'd1);
            check($sformatf("lo_hidden_%0d", k), RdData, 32'd0);
            step();
        end
        check("stall_after", 32'(Stall), 32'd0);
        check("busy_after_mult", 32'(Busy), 32'd0);
        check("mflo_new_lo", RdData, 32'd30);
        MdUseD = 1'b0;

        // Flushed div must not start; mthi lands only after the edge.
        Flush = 1'b1; MdOp = 3'd3; Operand1 = 32'd50; Operand2 = 32'd5;
        step();
        Flush = 1'b0; MdOp = 3'd0;
        check("flush_busy", 32'(Busy), 32'd0);
        step();
        check("flush_hi", HI, 32'd0);
        check("flush_lo", LO, 32'd30);
        MdOp = 3'd5; Operand1 = 32'h1234; RdSel = 1'b1;
        #1;
        check("mthi_no_bypass", RdData, 32'd0);
        step();
        MdOp = 3'd0;
        check("mthi_hi", HI, 32'h1234);
        check("mthi_busy", 32'(Busy), 32'd0);

        // Reset at busy cycle 3 of a div aborts it.
        MdOp = 3'd3; Operand1 = 32'd100; Operand2 = 32'd3;
        step();
        MdOp = 3'd0;
        step();
        step();
        check("pre_reset_busy", 32'(Busy), 32'd1);
        reset = 1'b1; MdUseD = 1'b1;
        step();
        check("midrst_busy", 32'(Busy), 32'd0);
        check("midrst_stall", 32'(Stall), 32'd0);
        check("midrst_hi", HI, 32'd0);
        check("midrst_lo", LO, 32'd0);
        reset = 1'b0; MdUseD = 1'b0;
        MdOp = 3'd1; Operand1 = 32'd3; Operand2 = 32'd4;
        step();
        MdOp = 3'd0;
        count_busy(bc);
        check("postrst_busy_cycles", 32'(bc), 32'd5);
        check("postrst_lo", LO, 32'd12);
        check("postrst_hi", HI, 32'd0);

        // Back-to-back: div held in EX during the mult is ignored, then accepted as Busy drops.
        MdOp = 3'd1; Operand1 = 32'd2; Operand2 = 32'd3;
        step();
        MdOp = 3'd3; Operand1 = 32'd9; Operand2 = 32'd2; MdUseD = 1'b1;
        total = 0;
        while (Busy && total < 40) begin
            Flush = (total == 1);
            total++;
            step();
        end
        Flush = 1'b0;
        check("b2b_mult_cycles", 32'(total), 32'd5);
        check("b2b_mult_lo", LO, 32'd6);
        check("b2b_start_stall", 32'(Stall), 32'd1);
        step();
        MdOp = 3'd0; MdUseD = 1'b0;
        count_busy(bc);
        total += bc;
        check("b2b_total_cycles", 32'(total), 32'd15);
        check("b2b_div_lo", LO, 32'd4);
        check("b2b_div_hi", HI, 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
